if_fetch_stage: RTL and testbench

Instruction-fetch stage directly upstream of the IF/ID pipeline register. It owns the PC, issues word fetches to instruction memory over a req/ready handshake, and handles multi-cycle memory waits, hazard-unit stalls and branch/jump redirects. Each cycle it presents a registered instruction word and its PC+4 for IF/ID to capture unconditionally. It inserts NOP bubbles when no valid instruction is available, and holds its outputs steady during a stall.

---
 rtl/if_fetch_stage.sv | 131 +++++++++++++
 tb/tb_if_fetch_stage.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ready handshake,
// and feeds a registered instruction plus PC+4 to the IF/ID register every cycle.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic [31:0] pcp4,
  output logic        ins_valid,
  output logic [1:0]  dbg_state
);

  // Handshake: a fetch completes on a cycle with imem_req & imem_ready; while
  // imem_req=1 and imem_ready=0 imem_addr holds, and imem_rdata is ignored otherwise.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_buf_q, hold_buf_d;
  logic [31:0] tgt_r_q, tgt_r_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        ins_valid_q, ins_valid_d;
  logic [31:0] target;
  logic [31:0] pc_inc;

  assign target    = {redirect_pc[31:2], 2'b00};
  assign pc_inc    = pc_q + 32'd4;
  assign imem_addr = pc_q;
  assign imem_req  = rst_n & (state_q != HOLD);
  assign ins       = ins_q;
  assign pcp4      = pcp4_q;
  assign ins_valid = ins_valid_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_buf_d  = hold_buf_q;
    tgt_r_d     = tgt_r_q;
    ins_d       = ins_q;
    pcp4_d      = pcp4_q;
    ins_valid_d = ins_valid_q;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          ins_d       = NOP_WORD;
          ins_valid_d = 1'b0;
          if (imem_ready) begin
            pc_d = target;
          end else begin
            // The in-flight request must still complete, so wait it out in DROP.
            tgt_r_d = target;
            state_d = DROP;
          end
        end else if (stall) begin
          if (imem_ready) begin
            hold_buf_d = imem_rdata;
            state_d    = HOLD;
          end
        end else if (imem_ready) begin
          ins_d       = imem_rdata;
          pcp4_d      = pc_inc;
          ins_valid_d = 1'b1;
          pc_d        = pc_inc;
        end else begin
          ins_d       = NOP_WORD;
          ins_valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d        = target;
          ins_d       = NOP_WORD;
          ins_valid_d = 1'b0;
          state_d     = FETCH;
        end else if (!stall) begin
          ins_d       = hold_buf_q;
          pcp4_d      = pc_inc;
          ins_valid_d = 1'b1;
          pc_d        = pc_inc;
          state_d     = FETCH;
        end
      end
      DROP: begin
        ins_d       = NOP_WORD;
        ins_valid_d = 1'b0;
        if (redirect) tgt_r_d = target;
        if (imem_ready) begin
          pc_d    = redirect ? target : tgt_r_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      hold_buf_q  <= 32'h0;
      tgt_r_q     <= 32'h0;
      ins_q       <= NOP_WORD;
      pcp4_q      <= RESET_PC;
      ins_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_buf_q  <= hold_buf_d;
      tgt_r_q     <= tgt_r_d;
      ins_q       <= ins_d;
      pcp4_q      <= pcp4_d;
      ins_valid_q <= ins_valid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: memory returns addr ^ A5A5_0000, expected
// outputs are queued as each cycle is driven and compared after the clock edge.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] ins;
  logic [31:0] pcp4;
  logic        ins_valid;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [64:0] exp_q[$];

  localparam logic [31:0] NOP = 32'h0000_0000;

  if_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .ins(ins), .pcp4(pcp4),
    .ins_valid(ins_valid), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s mismatched", tag);
    end
  endtask

  // One cycle: drive inputs at negedge, check request side, queue expected
  // registered outputs, then pop and compare them just after the posedge.
  task automatic cyc(input logic st, input logic rd, input logic [31:0] rpc,
                     input logic rdy, input logic e_req, input logic [31:0] e_addr,
                     input logic [31:0] e_ins, input logic [31:0] e_pcp4,
                     input logic e_v, input string tag);
    logic [64:0] e;
    @(negedge clk);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ready  = rdy;
    imem_rdata  = rdy ? word(imem_addr) : $urandom();
    #1;
    chk({tag, ".req"}, {31'h0, imem_req}, {31'h0, e_req});
    chk({tag, ".addr"}, imem_addr, e_addr);
    exp_q.push_back({e_ins, e_pcp4, e_v});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ".ins"}, ins, e[64:33]);
    chk({tag, ".pcp4"}, pcp4, e[32:1]);
    chk({tag, ".valid"}, {31'h0, ins_valid}, {31'h0, e[0]});
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst.req", {31'h0, imem_req}, 32'h0);
    chk("rst.ins", ins, NOP);
    chk("rst.pcp4", pcp4, 32'h0);
    chk("rst.valid", {31'h0, ins_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Sequential fetch
    cyc(0, 0, 0, 1, 1, 32'h0,  word(32'h0), 32'h4, 1, "seq0");
    cyc(0, 0, 0, 1, 1, 32'h4,  word(32'h4), 32'h8, 1, "seq4");
    // Memory wait at 8: two bubbles, address held
    cyc(0, 0, 0, 0, 1, 32'h8,  NOP, 32'h8, 0, "wait1");
    cyc(0, 0, 0, 0, 1, 32'h8,  NOP, 32'h8, 0, "wait2");
    cyc(0, 0, 0, 1, 1, 32'h8,  word(32'h8), 32'hC, 1, "seq8");
    cyc(0, 0, 0, 1, 1, 32'hC,  word(32'hC), 32'h10, 1, "seqC");
    // Stall while word at 0x10 returns
    cyc(1, 0, 0, 1, 1, 32'h10, word(32'hC), 32'h10, 1, "stl1");
    cyc(1, 0, 0, 1, 0, 32'h10, word(32'hC), 32'h10, 1, "stl2");
    cyc(1, 0, 0, 1, 0, 32'h10, word(32'hC), 32'h10, 1, "stl3");
    cyc(0, 0, 0, 1, 0, 32'h10, word(32'h10), 32'h14, 1, "unstl");
    cyc(0, 0, 0, 1, 1, 32'h14, word(32'h14), 32'h18, 1, "seq14");
    cyc(0, 0, 0, 1, 1, 32'h18, word(32'h18), 32'h1C, 1, "seq18");
    cyc(0, 0, 0, 1, 1, 32'h1C, word(32'h1C), 32'h20, 1, "seq1C");
    // Redirect to 0x103 while fetch of 0x20 waits
    cyc(0, 1, 32'h103, 0, 1, 32'h20, NOP, 32'h20, 0, "rdr1");
    cyc(0, 0, 0,       0, 1, 32'h20, NOP, 32'h20, 0, "drop1");
    cyc(0, 0, 0,       1, 1, 32'h20, NOP, 32'h20, 0, "drop2");
    cyc(0, 0, 0,       1, 1, 32'h100, word(32'h100), 32'h104, 1, "tgt100");
    // Redirect and stall together from HOLD
    cyc(1, 0, 0,       1, 1, 32'h104, word(32'h100), 32'h104, 1, "hold");
    cyc(1, 1, 32'h200, 1, 0, 32'h104, NOP, 32'h104, 0, "hrdr");
    cyc(0, 0, 0,       1, 1, 32'h200, word(32'h200), 32'h204, 1, "tgt200");
    // Stall during a memory wait keeps outputs
    cyc(1, 0, 0,       0, 1, 32'h204, word(32'h200), 32'h204, 1, "stlw");
    // Wrap at top of address space (low bits of target ignored)
    cyc(0, 1, 32'hFFFF_FFFF, 1, 1, 32'h204, NOP, 32'h204, 0, "rdrtop");
    cyc(0, 0, 0, 1, 1, 32'hFFFF_FFFC, word(32'hFFFF_FFFC), 32'h0, 1, "wrap");
    cyc(0, 0, 0, 1, 1, 32'h0, word(32'h0), 32'h4, 1, "after");
    // DROP: stall ignored, latest redirect wins
    cyc(0, 1, 32'h300, 0, 1, 32'h4, NOP, 32'h4, 0, "d_rdr");
    cyc(1, 1, 32'h400, 0, 1, 32'h4, NOP, 32'h4, 0, "d_rdr2");
    cyc(0, 0, 0,       1, 1, 32'h4, NOP, 32'h4, 0, "d_done");
    cyc(0, 0, 0,       1, 1, 32'h400, word(32'h400), 32'h404, 1, "tgt400");
    cyc(0, 0, 0,       0, 1, 32'h404, NOP, 32'h404, 0, "w404");
    // Reset asserted mid-wait
    @(negedge clk);
    imem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst.req", {31'h0, imem_req}, 32'h0);
    chk("mrst.addr", imem_addr, 32'h0);
    chk("mrst.ins", ins, NOP);
    chk("mrst.pcp4", pcp4, 32'h0);
    chk("mrst.valid", {31'h0, ins_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 1, 1, 32'h0, word(32'h0), 32'h4, 1, "post_rst");

    chk("q_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
